// File: rtl/operand_bank_loader.sv
// Realigns ROM/RAM read data with the controller selects, fills per-bank
// operand registers and streams full banks. Parity option: OPERAND_PARITY_EN.
module operand_bank_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int BANKS        = 8,
  parameter int ELEMS        = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        read_en,
  input  logic [3:0]                  bank_sel,
  input  logic [2:0]                  elem_sel,
  input  logic [DATA_WIDTH-1:0]       rom_data,
  input  logic [DATA_WIDTH-1:0]       ram_data,
`ifdef OPERAND_PARITY_EN
  input  logic                        rom_par,
  input  logic                        ram_par,
  output logic                        parity_err,
`endif
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [2:0]                  out_bank,
  output logic [ELEMS*DATA_WIDTH-1:0] a_row,
  output logic [ELEMS*DATA_WIDTH-1:0] b_row,
  output logic [BANKS-1:0]            bank_full,
  output logic                        load_done,
  output logic                        overflow_err
);

  typedef struct packed {
    logic       v;
    logic [3:0] bank;
    logic [2:0] elem;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  typedef logic [ELEMS-1:0][DATA_WIDTH-1:0] row_t;

  tag_t                        tag_q [READ_LATENCY];
  tag_t                        tag_out;

  state_t                      state_q, state_d;
  logic [2:0]                  ptr_q, ptr_d;
  logic [BANKS-1:0][ELEMS-1:0] vld_q, vld_d;
  logic [BANKS-1:0]            full_q, full_d;
  logic                        ovf_q, ovf_d;
  logic                        done_q, done_d;

  row_t                        a_q [BANKS];
  row_t                        b_q [BANKS];

  logic [2:0]                  wr_bank;
  logic [2:0]                  wr_elem;
  logic                        wr_hit;
  logic                        wr_blk;
  logic                        wr_ok;
  logic                        drain;

  assign tag_out = tag_q[READ_LATENCY-1];
  assign wr_bank = tag_out.bank[2:0];
  assign wr_elem = tag_out.elem;

  assign wr_hit = tag_out.v
                && (tag_out.bank < 4'(BANKS))
                && ({1'b0, tag_out.elem} < 4'(ELEMS));

  assign out_valid = (state_q == STREAM) && full_q[ptr_q];
  assign drain     = out_valid && out_ready;

  // A bank being drained this cycle is already empty for the arriving write.
  assign wr_blk = full_q[wr_bank] && !(drain && (wr_bank == ptr_q));
  assign wr_ok  = wr_hit && !wr_blk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {read_en, bank_sel, elem_sel};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (drain) begin
      vld_d[ptr_q]  = '0;
      full_d[ptr_q] = 1'b0;
    end
    if (wr_hit && wr_blk) begin
      ovf_d = 1'b1;
    end
    if (wr_ok) begin
      vld_d[wr_bank][wr_elem] = 1'b1;
      if (&vld_d[wr_bank]) begin
        full_d[wr_bank] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_ok) state_d = STREAM;
      end
      STREAM: begin
        if (drain) begin
          if (ptr_q == 3'(BANKS-1)) begin
            ptr_d   = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (wr_ok) state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      vld_q   <= '0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      vld_q   <= '0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Operand storage carries no reset; element-valid bits qualify it.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      a_q[wr_bank][wr_elem] <= rom_data;
      b_q[wr_bank][wr_elem] <= ram_data;
    end
  end

`ifdef OPERAND_PARITY_EN
  logic par_q;
  logic par_bad;

  assign par_bad = ((^rom_data) ^ rom_par) | ((^ram_data) ^ ram_par);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (clear) begin
      par_q <= 1'b0;
    end else if (wr_ok && par_bad) begin
      par_q <= 1'b1;
    end
  end

  assign parity_err = par_q;
`endif

  assign a_row        = out_valid ? a_q[ptr_q] : '0;
  assign b_row        = out_valid ? b_q[ptr_q] : '0;
  assign out_bank     = ptr_q;
  assign bank_full    = full_q;
  assign load_done    = done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_operand_bank_loader.sv
// Bench for operand_bank_loader: directed scenarios plus random traffic,
// all checked each cycle against a queue/array model of the loader.
module tb_operand_bank_loader;

  localparam int DW = 32;
  localparam int NB = 8;
  localparam int NE = 8;
  localparam int RL = 2;
  localparam int W  = NE * DW;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          clear     = 1'b0;
  logic          read_en   = 1'b0;
  logic [3:0]    bank_sel  = '0;
  logic [2:0]    elem_sel  = '0;
  logic [DW-1:0] rom_data  = '0;
  logic [DW-1:0] ram_data  = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [2:0]    out_bank;
  logic [W-1:0]  a_row;
  logic [W-1:0]  b_row;
  logic [NB-1:0] bank_full;
  logic          load_done;
  logic          overflow_err;
`ifdef OPERAND_PARITY_EN
  logic          rom_par = 1'b0;
  logic          ram_par = 1'b0;
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  operand_bank_loader #(
    .DATA_WIDTH(DW), .BANKS(NB), .ELEMS(NE), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .read_en(read_en),
    .bank_sel(bank_sel),
    .elem_sel(elem_sel),
    .rom_data(rom_data),
    .ram_data(ram_data),
`ifdef OPERAND_PARITY_EN
    .rom_par(rom_par),
    .ram_par(ram_par),
    .parity_err(parity_err),
`endif
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bank(out_bank),
    .a_row(a_row),
    .b_row(b_row),
    .bank_full(bank_full),
    .load_done(load_done),
    .overflow_err(overflow_err)
  );

  typedef struct {
    bit v;
    int b;
    int e;
  } tag_s;

  int            tests = 0;
  int            fails = 0;

  tag_s          tq[$];
  logic [DW-1:0] mA [NB][NE];
  logic [DW-1:0] mB [NB][NE];
  bit            mv [NB][NE];
  bit            mfull [NB];
  int            mode;
  int            mptr;
  bit            movf, mdone, mpar;

  logic [DW-1:0] romMem [NB][NE];
  logic [DW-1:0] ramMem [NB][NE];
  bit            rnd_data, d_pflip;
  bit            d_clear, d_re, d_rdy;
  int            d_bank, d_elem;

  int            hs_q[$];
  logic [DW-1:0] a53;
  int            ld_cnt;
  logic [W-1:0]  er;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    tq.delete();
    for (int i = 0; i < RL; i++) tq.push_back('{v: 1'b0, b: 0, e: 0});
    for (int b = 0; b < NB; b++) begin
      mfull[b] = 1'b0;
      for (int e = 0; e < NE; e++) mv[b][e] = 1'b0;
    end
    mode = 0; mptr = 0;
    movf = 1'b0; mdone = 1'b0; mpar = 1'b0;
  endtask

  function automatic bit m_valid();
    return (mode == 1) && mfull[mptr];
  endfunction

  task automatic model_step(input logic [DW-1:0] rd, input logic [DW-1:0] md,
                            input bit rp, input bit mp);
    tag_s t;
    bit   dr, st, all;
    int   nm;
    if (d_clear) begin
      model_clear();
      return;
    end
    t = tq.pop_front();
    tq.push_back('{v: d_re, b: d_bank, e: d_elem});
    dr = m_valid() && d_rdy;
    nm = mode;
    mdone = 1'b0;
    if (dr) begin
      mfull[mptr] = 1'b0;
      for (int e = 0; e < NE; e++) mv[mptr][e] = 1'b0;
      if (mptr == NB - 1) begin
        mptr = 0; mdone = 1'b1; nm = 2;
      end else begin
        mptr++;
      end
    end
    st = 1'b0;
    if (t.v && t.b < NB) begin
      if (mfull[t.b]) begin
        movf = 1'b1;
      end else begin
        mA[t.b][t.e] = rd;
        mB[t.b][t.e] = md;
        mv[t.b][t.e] = 1'b1;
        st = 1'b1;
        all = 1'b1;
        for (int e = 0; e < NE; e++) if (!mv[t.b][e]) all = 1'b0;
        if (all) mfull[t.b] = 1'b1;
        if (((^rd) != rp) || ((^md) != mp)) mpar = 1'b1;
      end
    end
    if (mode != 1 && st) nm = 1;
    mode = nm;
  endtask

  task automatic check_outputs();
    logic [W-1:0]  ea, eb;
    logic [NB-1:0] ef;
    bit            v;
    v  = m_valid();
    ea = '0;
    eb = '0;
    if (v) begin
      for (int e = 0; e < NE; e++) begin
        ea[e*DW +: DW] = mA[mptr][e];
        eb[e*DW +: DW] = mB[mptr][e];
      end
    end
    for (int b = 0; b < NB; b++) ef[b] = mfull[b];
    chk("out_valid", W'(out_valid), W'(v));
    chk("out_bank", W'(out_bank), W'(mptr));
    chk("a_row", a_row, ea);
    chk("b_row", b_row, eb);
    chk("bank_full", W'(bank_full), W'(ef));
    chk("load_done", W'(load_done), W'(mdone));
    chk("overflow_err", W'(overflow_err), W'(movf));
`ifdef OPERAND_PARITY_EN
    chk("parity_err", W'(parity_err), W'(mpar));
`endif
  endtask

  task automatic cycle();
    tag_s          t;
    logic [DW-1:0] rd, md;
    bit            rp, mp;
    @(negedge clk);
    t = tq[0];
    if (t.v && t.b < NB && !rnd_data) begin
      rd = romMem[t.b][t.e];
      md = ramMem[t.b][t.e];
    end else begin
      rd = $urandom;
      md = $urandom;
    end
    rp = (^rd) ^ d_pflip;
    mp = ^md;
    clear     = d_clear;
    read_en   = d_re;
    bank_sel  = 4'(d_bank);
    elem_sel  = 3'(d_elem);
    out_ready = d_rdy;
    rom_data  = rd;
    ram_data  = md;
`ifdef OPERAND_PARITY_EN
    rom_par = rp;
    ram_par = mp;
`endif
    if (out_valid && out_ready) begin
      hs_q.push_back(int'(out_bank));
      if (out_bank == 3'd5) a53 = a_row[3*DW +: DW];
    end
    model_step(rd, md, rp, mp);
    @(posedge clk);
    #1;
    check_outputs();
    if (load_done) ld_cnt++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      d_clear = 1'b0; d_re = 1'b0; d_rdy = rdy;
      cycle();
    end
  endtask

  task automatic issue(input int b, input int e, input bit rdy);
    d_clear = 1'b0; d_re = 1'b1; d_bank = b; d_elem = e; d_rdy = rdy;
    cycle();
  endtask

  task automatic do_clear();
    d_clear = 1'b1; d_re = 1'b0; d_rdy = 1'b0;
    cycle();
    d_clear = 1'b0;
  endtask

  task automatic load_bank(input int b, input bit rdy);
    for (int e = 0; e < NE; e++) issue(b, e, rdy);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      for (int e = 0; e < NE; e++) begin
        romMem[b][e] = DW'(b * 8 + e);
        ramMem[b][e] = DW'(32'h100 + b * 8 + e);
      end
    end
    d_clear = 0; d_re = 0; d_rdy = 0; d_bank = 0; d_elem = 0;
    rnd_data = 0; d_pflip = 0; ld_cnt = 0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_bank", W'(out_bank), W'(0));
    chk("rst_a_row", a_row, W'(0));
    chk("rst_bank_full", W'(bank_full), W'(0));
    chk("rst_load_done", W'(load_done), W'(0));
    chk("rst_overflow", W'(overflow_err), W'(0));
    reset = 1'b0;

    // full load, out_ready high
    for (int b = 0; b < NB; b++) load_bank(b, 1'b1);
    idle(RL + 4, 1'b1);
    chk("full_hs_count", W'(hs_q.size()), W'(8));
    for (int i = 0; i < hs_q.size() && i < 8; i++)
      chk("full_hs_bank", W'(hs_q[i]), W'(i));
    chk("full_a_b5_e3", W'(a53), W'(43));
    chk("full_load_done_cycles", W'(ld_cnt), W'(1));

    // backpressure on bank 0, plus an overflowing write
    do_clear();
    load_bank(0, 1'b0);
    idle(RL + 1, 1'b0);
    for (int e = 0; e < NE; e++) er[e*DW +: DW] = romMem[0][e];
    rnd_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) issue(0, 3, 1'b0);
      else idle(1, 1'b0);
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_a_row", a_row, er);
    end
    rnd_data = 1'b0;
    chk("bp_overflow", W'(overflow_err), W'(1));
    idle(2, 1'b1);

    // terminator bank select
    do_clear();
    for (int i = 0; i < 3; i++) issue(8, i, 1'b0);
    idle(RL + 2, 1'b0);
    chk("term_bank_full", W'(bank_full), W'(0));
    chk("term_overflow", W'(overflow_err), W'(0));

    // drain of bank 2 coincides with a write to bank 2
    do_clear();
    for (int b = 0; b < 3; b++) load_bank(b, 1'b0);
    idle(RL + 1, 1'b0);
    idle(2, 1'b1);
    chk("sb_out_bank", W'(out_bank), W'(2));
    chk("sb_out_valid", W'(out_valid), W'(1));
    for (int i = 0; i <= RL; i++) begin
      if (i == 0) issue(2, 0, 1'b0);
      else idle(1, (i == RL));
    end
    chk("sb_full2_cleared", W'(bank_full[2]), W'(0));
    chk("sb_overflow", W'(overflow_err), W'(0));
    for (int e = 1; e < NE; e++) issue(2, e, 1'b0);
    idle(RL + 1, 1'b0);
    chk("sb_refill", W'(bank_full[2]), W'(1));

    // clear while bank 4 is presented
    do_clear();
    for (int b = 0; b < 5; b++) load_bank(b, 1'b0);
    idle(RL + 1, 1'b0);
    idle(4, 1'b1);
    chk("cm_out_bank", W'(out_bank), W'(4));
    chk("cm_out_valid", W'(out_valid), W'(1));
    do_clear();
    chk("cm_valid_after", W'(out_valid), W'(0));
    chk("cm_full_after", W'(bank_full), W'(0));

    // async reset mid-cycle while a row is presented
    load_bank(0, 1'b0);
    idle(RL + 1, 1'b0);
    chk("rs_valid_before", W'(out_valid), W'(1));
    #2 reset = 1'b1;
    #1;
    chk("rs_out_valid", W'(out_valid), W'(0));
    chk("rs_bank_full", W'(bank_full), W'(0));
    chk("rs_a_row", a_row, W'(0));
    chk("rs_b_row", b_row, W'(0));
    chk("rs_overflow", W'(overflow_err), W'(0));
    model_clear();
    @(negedge clk);
    reset = 1'b0;

`ifdef OPERAND_PARITY_EN
    do_clear();
    d_pflip = 1'b1;
    issue(0, 0, 1'b0);
    idle(RL, 1'b0);
    d_pflip = 1'b0;
    for (int e = 1; e < NE; e++) issue(0, e, 1'b0);
    idle(RL + 1, 1'b0);
    chk("par_err_set", W'(parity_err), W'(1));
    chk("par_data_kept", W'(a_row[0 +: DW]), W'(romMem[0][0]));
    do_clear();
    chk("par_err_cleared", W'(parity_err), W'(0));
`endif

    // random traffic
    rnd_data = 1'b1;
    repeat (2500) begin
      d_clear = ($urandom_range(0, 299) == 0);
      d_re    = ($urandom_range(0, 3) != 0);
      d_bank  = ($urandom_range(0, 15) == 0) ? 8 : $urandom_range(0, 7);
      d_elem  = $urandom_range(0, 7);
      d_rdy   = ($urandom_range(0, 2) != 0);
      cycle();
    end
    do_clear();
    for (int m = 0; m < 4; m++) begin
      for (int b = 0; b < NB; b++) begin
        for (int e = 0; e < NE; e++) begin
          idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
          issue(b, e, 1'($urandom_range(0, 3) != 0));
        end
      end
      idle(RL + 3, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
